neuron_buffer_swap_ctrl: RTL and testbench
==========================================

// Module: neuron_buffer_swap_ctrl
// PURPOSE
//  Layer sequencer for the N1/N2 ping-pong neuron buffers. Owns readBufferSelect and generates the
//  read-side address stream (input neurons to the conv unit) and write-side address stream (pooled
//  outputs from the pool unit) for one layer. It then flips the buffers so that layer's output
//  becomes the next layer's input. Sits directly upstream of the buffer swapper and drives its
//  select and address inputs.
// PARAMETERS
//  A      7   buffer address width, in words of D*W bits
//  CW     A+1 length-field width, so a layer may span all 2^A words
// PORTS
//  clk               in   1   system clock
//  reset             in   1   synchronous, active-high reset
//  start             in   1   1-cycle pulse: begin a layer; sampled only in IDLE
//  inLen             in   CW  words to read this layer; latched on accepted start
//  outLen            in   CW  words expected to be written this layer; latched on accepted start
//  readStall         in   1   conv unit back-pressure; holds the read stream
//  poolValid         in   1   pool unit presents one output word this cycle
//  readBufferSelect  out  1   0: N1 read / N2 written; 1: N2 read / N1 written
//  readBuffAddress   out  A   read-side word address
//  readEn            out  1   read issued at readBuffAddress this cycle
//  writeBuffAddress  out  A   write-side word address
//  writeEn           out  1   write accepted at writeBuffAddress this cycle
//  busy              out  1   state != IDLE
//  layerDone         out  1   1-cycle pulse in SWAP
//  overflow          out  1   sticky: poolValid seen with wrCnt==outLen; cleared by reset/accepted start
// BEHAVIOUR
//  Reset: state=IDLE; readBufferSelect=0; rdCnt=wrCnt=0; readEn=writeEn=layerDone=overflow=0; busy=0.
//   Reset mid-layer aborts at once, with no swap and no layerDone.
//  Outputs: readBuffAddress=rdCnt[A-1:0], writeBuffAddress=wrCnt[A-1:0] (both registered counters).
//   readEn = (state==READ)&&!readStall; writeEn = poolValid&&(state in READ,DRAIN)&&(wrCnt<outLen).
//   readEn and writeEn are combinational from those terms.
//  FSM IDLE -> READ -> DRAIN -> SWAP -> IDLE:
//   IDLE : start=1 latches inLen/outLen, clears rdCnt, wrCnt and overflow.
//          Next state is READ if inLen!=0, DRAIN if inLen==0.
//   READ : each readEn cycle, rdCnt++. The cycle issuing address inLen-1 moves to DRAIN.
//          Latency: start at cycle t gives readEn with address 0 at t+1, if not stalled.
//   DRAIN: waits until wrCnt==outLen, then moves to SWAP. If outLen==0, one DRAIN cycle then SWAP.
//   SWAP : single cycle; layerDone=1; readBufferSelect toggles on the closing edge; next state IDLE.
//  Writes: poolValid is accepted in READ and DRAIN (writes overlap reads); each writeEn gives wrCnt++.
//   poolValid in IDLE/SWAP, or when wrCnt==outLen, is dropped with writeEn=0.
//   The wrCnt==outLen case also sets overflow (outside IDLE/SWAP).
//  Simultaneous readEn and writeEn are legal; they target opposite buffers per readBufferSelect.
//  Boundary: start while busy is ignored, with no re-latch. Length 2^A: last address is 2^A-1;
//   the counter reaches 2^A in CW bits, with no wrap and no address alias.
//  readStall in READ: rdCnt and readBuffAddress hold, readEn=0; the write side continues.
//  readBufferSelect changes only in SWAP or on reset, never mid-layer.
// TESTING
//  1 reset: after reset, select=0, addresses=0, busy=0. start with inLen=4, outLen=2:
//    readEn at t+1..t+4 with addresses 0,1,2,3. poolValid twice gives writes at 0,1.
//    Then layerDone, and select=1 on the next cycle.
//  2 readStall high on the cycle of read address 2 (inLen=4): address 2 repeats with readEn=0,
//    then 2,3 follow; the total readEn count is 4.
//  3 outLen=3 with poolValid held high for 5 cycles: writes at 0,1,2 only;
//    overflow=1 from the 4th pulse; SWAP is still reached.
//  4 inLen=0, outLen=0: start, one DRAIN cycle, then SWAP. layerDone at t+2; select toggles.
//  5 two back-to-back layers: select goes 0->1->0. start pulsed during layer 1 is ignored.
//  6 reset asserted mid-READ with select=1: state returns to IDLE and select goes to 0;
//    no layerDone pulse occurs.
//  7 inLen=128 (A=7): last read address is 127, there is no wrap, then DRAIN.

Source files
------------

// File: rtl/neuron_buffer_swap_ctrl.sv
// neuron_buffer_swap_ctrl: layer sequencer for the N1/N2 ping-pong neuron buffers
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   start, inLen, outLen   layer kick-off pulse and per-layer read/write lengths (latched on start)
//   readStall              conv-side back-pressure on the read stream
//   poolValid              pool unit offers one output word this cycle
//   readBufferSelect       0: N1 read / N2 written; 1: N2 read / N1 written
//   readBuffAddress/readEn    read-side address and strobe
//   writeBuffAddress/writeEn  write-side address and strobe
//   busy, layerDone        sequencer activity and end-of-layer pulse
//   overflow               sticky: pool word arrived after outLen words were already written
module neuron_buffer_swap_ctrl #(
    parameter int A  = 7,
    parameter int CW = A + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] inLen,
    input  logic [CW-1:0] outLen,
    input  logic          readStall,
    input  logic          poolValid,
    output logic          readBufferSelect,
    output logic [A-1:0]  readBuffAddress,
    output logic          readEn,
    output logic [A-1:0]  writeBuffAddress,
    output logic          writeEn,
    output logic          busy,
    output logic          layerDone,
    output logic          overflow
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, SWAP} state_t;
    localparam logic [CW-1:0] ONE = CW'(1);
    state_t        state, state_nxt;
    logic [CW-1:0] rd_cnt, wr_cnt, in_len, out_len;
    logic          pool_in, accept;
    assign accept           = (state == IDLE) && start;
    // pool words are only meaningful while the layer is streaming
    assign pool_in          = poolValid && ((state == READ) || (state == DRAIN));
    assign readEn           = (state == READ) && !readStall;
    assign writeEn          = pool_in && (wr_cnt < out_len);
    assign busy             = state != IDLE;
    assign layerDone        = state == SWAP;
    // counters are CW bits wide so a full 2^A-word layer reaches 2^A without wrapping
    assign readBuffAddress  = rd_cnt[A-1:0];
    assign writeBuffAddress = wr_cnt[A-1:0];
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = !start ? IDLE : (inLen != '0) ? READ : DRAIN;
            READ:  state_nxt = (readEn && (rd_cnt + ONE == in_len)) ? DRAIN : READ;
            DRAIN: state_nxt = (wr_cnt == out_len) ? SWAP : DRAIN;
            SWAP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            readBufferSelect <= 1'b0;
            rd_cnt           <= '0;
            wr_cnt           <= '0;
            in_len           <= '0;
            out_len          <= '0;
            overflow         <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                in_len   <= inLen;
                out_len  <= outLen;
                rd_cnt   <= '0;
                wr_cnt   <= '0;
                overflow <= 1'b0;
            end else begin
                if (readEn) rd_cnt <= rd_cnt + ONE;
                if (writeEn) wr_cnt <= wr_cnt + ONE;
                if (pool_in && (wr_cnt == out_len)) overflow <= 1'b1;
            end
            if (state == SWAP) readBufferSelect <= !readBufferSelect;
        end
    end
endmodule

// File: tb/tb_neuron_buffer_swap_ctrl.sv
// tb_neuron_buffer_swap_ctrl: directed self-checking bench for neuron_buffer_swap_ctrl
module tb_neuron_buffer_swap_ctrl;
    localparam int A  = 7;
    localparam int CW = A + 1;
    logic          clk = 1'b0;
    logic          reset, start, readStall, poolValid;
    logic [CW-1:0] inLen, outLen;
    logic          readBufferSelect, readEn, writeEn, busy, layerDone, overflow;
    logic [A-1:0]  readBuffAddress, writeBuffAddress;
    int            tests = 0;
    int            fails = 0;
    int            rd_seen;
    always #5 clk = ~clk;
    neuron_buffer_swap_ctrl #(.A(A), .CW(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .inLen(inLen), .outLen(outLen),
        .readStall(readStall), .poolValid(poolValid),
        .readBufferSelect(readBufferSelect), .readBuffAddress(readBuffAddress), .readEn(readEn),
        .writeBuffAddress(writeBuffAddress), .writeEn(writeEn), .busy(busy),
        .layerDone(layerDone), .overflow(overflow)
    );
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    initial begin
        reset = 1; start = 0; inLen = 0; outLen = 0; readStall = 0; poolValid = 0;
        // 1: reset state, then a 4-read / 2-write layer
        cyc; cyc; #1;
        chk("rst_sel", readBufferSelect, 0);
        chk("rst_raddr", readBuffAddress, 0);
        chk("rst_waddr", writeBuffAddress, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ren", readEn, 0);
        chk("rst_done", layerDone, 0);
        chk("rst_ovf", overflow, 0);
        reset = 0; start = 1; inLen = 4; outLen = 2; poolValid = 1; #1;
        chk("t1_idle_wen", writeEn, 0);
        chk("t1_idle_busy", busy, 0);
        cyc; start = 0;
        for (int i = 0; i < 4; i++) begin
            poolValid = (i < 2); #1;
            chk($sformatf("t1_ren%0d", i), readEn, 1);
            chk($sformatf("t1_raddr%0d", i), readBuffAddress, i);
            chk($sformatf("t1_wen%0d", i), writeEn, (i < 2));
            if (i < 2) chk($sformatf("t1_waddr%0d", i), writeBuffAddress, i);
            cyc;
        end
        poolValid = 0; #1;
        chk("t1_drain_busy", busy, 1);
        chk("t1_drain_ren", readEn, 0);
        chk("t1_drain_done", layerDone, 0);
        cyc;
        chk("t1_swap_done", layerDone, 1);
        chk("t1_swap_sel", readBufferSelect, 0);
        cyc;
        chk("t1_idle_sel", readBufferSelect, 1);
        chk("t1_idle_done", layerDone, 0);
        chk("t1_end_busy", busy, 0);
        // 2: read stall on address 2
        start = 1; inLen = 4; outLen = 0; rd_seen = 0;
        cyc; start = 0;
        for (int i = 0; i < 5; i++) begin
            readStall = (i == 2); #1;
            chk($sformatf("t2_raddr%0d", i), readBuffAddress, (i < 3) ? i : i - 1);
            chk($sformatf("t2_ren%0d", i), readEn, (i != 2));
            if (readEn) rd_seen++;
            cyc;
        end
        readStall = 0;
        chk("t2_rd_total", rd_seen, 4);
        chk("t2_drain_busy", busy, 1);
        chk("t2_drain_done", layerDone, 0);
        cyc;
        chk("t2_swap_done", layerDone, 1);
        cyc;
        chk("t2_sel", readBufferSelect, 0);
        // 3: outLen=3 with poolValid held 5 cycles
        start = 1; inLen = 1; outLen = 3;
        cyc; start = 0;
        for (int i = 0; i < 5; i++) begin
            poolValid = 1; #1;
            chk($sformatf("t3_wen%0d", i), writeEn, (i < 3));
            if (i < 3) chk($sformatf("t3_waddr%0d", i), writeBuffAddress, i);
            chk($sformatf("t3_ovf%0d", i), overflow, (i == 4));
            chk($sformatf("t3_done%0d", i), layerDone, (i == 4));
            cyc;
        end
        poolValid = 0;
        chk("t3_sel", readBufferSelect, 1);
        chk("t3_ovf_sticky", overflow, 1);
        // 4: empty layer, one DRAIN cycle then SWAP
        start = 1; inLen = 0; outLen = 0;
        cyc; start = 0;
        chk("t4_drain_busy", busy, 1);
        chk("t4_drain_ren", readEn, 0);
        chk("t4_ovf_clr", overflow, 0);
        chk("t4_drain_done", layerDone, 0);
        cyc;
        chk("t4_swap_done", layerDone, 1);
        cyc;
        chk("t4_sel", readBufferSelect, 0);
        // 5: back-to-back layers, start during layer ignored
        start = 1; inLen = 2; outLen = 1;
        cyc;
        inLen = 5; poolValid = 1; #1;
        chk("t5_ren0", readEn, 1);
        chk("t5_wen0", writeEn, 1);
        cyc; start = 0; poolValid = 0;
        chk("t5_raddr1", readBuffAddress, 1);
        cyc;
        chk("t5_drain_ren", readEn, 0);
        chk("t5_drain_busy", busy, 1);
        cyc;
        chk("t5_swap1", layerDone, 1);
        cyc;
        chk("t5_sel1", readBufferSelect, 1);
        start = 1; inLen = 1; outLen = 0;
        cyc; start = 0;
        chk("t5_l2_ren", readEn, 1);
        cyc;
        chk("t5_l2_drain", layerDone, 0);
        cyc;
        chk("t5_swap2", layerDone, 1);
        cyc;
        chk("t5_sel2", readBufferSelect, 0);
        // 6: reset mid-READ with select=1
        start = 1; inLen = 0; outLen = 0;
        cyc; start = 0; cyc; cyc;
        chk("t6_pre_sel", readBufferSelect, 1);
        start = 1; inLen = 4; outLen = 1;
        cyc; start = 0; cyc;
        chk("t6_mid_raddr", readBuffAddress, 1);
        reset = 1;
        cyc; reset = 0; #1;
        chk("t6_busy", busy, 0);
        chk("t6_sel", readBufferSelect, 0);
        chk("t6_done", layerDone, 0);
        chk("t6_raddr", readBuffAddress, 0);
        cyc;
        chk("t6_done_after", layerDone, 0);
        chk("t6_busy_after", busy, 0);
        // 7: full 128-word layer
        start = 1; inLen = 128; outLen = 1;
        cyc; start = 0;
        for (int i = 0; i < 128; i++) begin
            poolValid = (i == 0); #1;
            chk($sformatf("t7_raddr%0d", i), readBuffAddress, i);
            chk($sformatf("t7_ren%0d", i), readEn, 1);
            cyc;
        end
        poolValid = 0;
        chk("t7_drain_ren", readEn, 0);
        chk("t7_drain_busy", busy, 1);
        chk("t7_drain_done", layerDone, 0);
        cyc;
        chk("t7_swap_done", layerDone, 1);
        cyc;
        chk("t7_sel", readBufferSelect, 1);
        chk("t7_idle", busy, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
